gat_layer_sequencer: RTL and testbench

//  Sequences gat_top through NUM_LAYERS GAT layers: collects BRAM-load completions, presents

---
 rtl/gat_layer_sequencer_if.sv | 22 ++
 rtl/gat_layer_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_gat_layer_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gat_layer_sequencer_if.sv
// Feature read/stream bundle between the layer sequencer and the feature BRAM / stream sink.
interface gat_layer_sequencer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int FEAT_ADDR_W = 18
);
    logic [FEAT_ADDR_W-1:0] feat_bram_addrb;
    logic [31:0]            feat_bram_dout;
    logic [DATA_WIDTH-1:0]  feat_tdata;
    logic                   feat_tvalid;
    logic                   feat_tlast;
    logic                   feat_tready;

    modport master (
        output feat_bram_addrb, feat_tdata, feat_tvalid, feat_tlast,
        input  feat_bram_dout, feat_tready
    );

    modport slave (
        input  feat_bram_addrb, feat_tdata, feat_tvalid, feat_tlast,
        output feat_bram_dout, feat_tready
    );
endinterface

// File: rtl/gat_layer_sequencer.sv
// Steps gat_top through NUM_LAYERS layers: gathers BRAM-load completions, waits for gat_ready,
// then streams the layer's new-feature BRAM out one element per handshake.
module gat_layer_sequencer #(
    parameter int NUM_LAYERS  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int FEAT_DEPTH  = 43328,
    parameter int FEAT_ADDR_W = 18,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 2**26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        cfg_abort,
    input  logic        h_data_load_done_i,
    input  logic        h_node_info_load_done_i,
    input  logic        wgt_load_done_i,
    input  logic        gat_ready,
    gat_layer_sequencer_if.master feat,
    output logic        gat_layer,
    output logic        h_data_bram_load_done,
    output logic        h_node_info_bram_load_done,
    output logic        wgt_bram_load_done,
    output logic        layer_done,
    output logic        busy,
    output logic        timeout_err,
    output logic [31:0] run_cycles
);
    localparam int KW      = (FEAT_DEPTH > 1) ? $clog2(FEAT_DEPTH) : 1;
    localparam int LW      = $clog2(RD_LAT + 1);
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [KW-1:0]      LAST_K     = KW'(FEAT_DEPTH - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [31:0]        TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic               gat_ready_q;
    logic               gat_ready_rise;
    logic               fetching;
    logic [LW-1:0]      lat_cnt;
    logic [KW-1:0]      word_idx;
    logic [LAYER_W-1:0] layer;
    logic               h_next;
    logic               n_next;
    logic               w_next;
    logic               unused_dout_hi;

    assign gat_ready_rise = gat_ready & ~gat_ready_q;
    assign gat_layer      = layer[0];
    assign h_next         = h_data_bram_load_done | h_data_load_done_i;
    assign n_next         = h_node_info_bram_load_done | h_node_info_load_done_i;
    assign w_next         = wgt_bram_load_done | wgt_load_done_i;
    assign unused_dout_hi = ^feat.feat_bram_dout[31:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= S_IDLE;
            gat_ready_q                <= 1'b0;
            fetching                   <= 1'b0;
            lat_cnt                    <= '0;
            word_idx                   <= '0;
            layer                      <= '0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
            layer_done                 <= 1'b0;
            busy                       <= 1'b0;
            timeout_err                <= 1'b0;
            run_cycles                 <= '0;
            feat.feat_bram_addrb       <= '0;
            feat.feat_tdata            <= '0;
            feat.feat_tvalid           <= 1'b0;
            feat.feat_tlast            <= 1'b0;
        end else begin
            gat_ready_q <= gat_ready;
            layer_done  <= 1'b0;
            // Abort wins over everything, including a start in the same cycle.
            if (cfg_abort) begin
                state                      <= S_IDLE;
                fetching                   <= 1'b0;
                lat_cnt                    <= '0;
                word_idx                   <= '0;
                layer                      <= '0;
                h_data_bram_load_done      <= 1'b0;
                h_node_info_bram_load_done <= 1'b0;
                wgt_bram_load_done         <= 1'b0;
                busy                       <= 1'b0;
                run_cycles                 <= '0;
                feat.feat_bram_addrb       <= '0;
                feat.feat_tdata            <= '0;
                feat.feat_tvalid           <= 1'b0;
                feat.feat_tlast            <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            state       <= S_LOAD;
                            busy        <= 1'b1;
                            timeout_err <= 1'b0;
                            layer       <= '0;
                        end
                    end
                    S_LOAD: begin
                        h_data_bram_load_done      <= h_next;
                        h_node_info_bram_load_done <= n_next;
                        wgt_bram_load_done         <= w_next;
                        if (h_next && n_next && w_next) begin
                            state      <= S_RUN;
                            run_cycles <= '0;
                        end
                    end
                    S_RUN: begin
                        if (run_cycles != 32'hFFFF_FFFF) begin
                            run_cycles <= run_cycles + 32'd1;
                        end
                        if (gat_ready_rise) begin
                            state                <= S_DRAIN;
                            word_idx             <= '0;
                            lat_cnt              <= '0;
                            fetching             <= 1'b1;
                            feat.feat_bram_addrb <= '0;
                        end else if (run_cycles == TIMEOUT_LAST) begin
                            state                      <= S_DONE;
                            timeout_err                <= 1'b1;
                            h_data_bram_load_done      <= 1'b0;
                            h_node_info_bram_load_done <= 1'b0;
                            wgt_bram_load_done         <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        // Either waiting out the BRAM read latency or holding a word for the sink.
                        if (fetching) begin
                            if (lat_cnt == LW'(RD_LAT)) begin
                                feat.feat_tdata  <= feat.feat_bram_dout[DATA_WIDTH-1:0];
                                feat.feat_tvalid <= 1'b1;
                                feat.feat_tlast  <= (word_idx == LAST_K);
                                fetching         <= 1'b0;
                            end else begin
                                lat_cnt <= lat_cnt + LW'(1);
                            end
                        end else if (feat.feat_tready) begin
                            feat.feat_tvalid <= 1'b0;
                            feat.feat_tlast  <= 1'b0;
                            if (word_idx == LAST_K) begin
                                state                      <= S_NEXT;
                                word_idx                   <= '0;
                                feat.feat_bram_addrb       <= '0;
                                layer_done                 <= 1'b1;
                                h_data_bram_load_done      <= 1'b0;
                                h_node_info_bram_load_done <= 1'b0;
                                wgt_bram_load_done         <= 1'b0;
                            end else begin
                                word_idx             <= word_idx + KW'(1);
                                feat.feat_bram_addrb <= FEAT_ADDR_W'({word_idx + KW'(1), 2'b00});
                                fetching             <= 1'b1;
                                lat_cnt              <= '0;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (layer == LAST_LAYER) begin
                            layer <= '0;
                            state <= S_DONE;
                        end else begin
                            layer <= layer + LAYER_W'(1);
                            state <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Self-checking bench for gat_layer_sequencer: load-flag table, two-layer streaming run with
// a scoreboard, timeout, abort and asynchronous reset.
module tb_gat_layer_sequencer;
    localparam int NUM_LAYERS  = 2;
    localparam int DATA_WIDTH  = 8;
    localparam int FEAT_DEPTH  = 8;
    localparam int FEAT_ADDR_W = 5;
    localparam int RD_LAT      = 2;
    localparam int TIMEOUT_CYC = 150;

    typedef struct {
        logic [7:0]             data;
        logic                   last;
        logic [FEAT_ADDR_W-1:0] addr;
    } exp_t;

    typedef struct {
        string name;
        int    h_off;
        int    n_off;
        int    w_off;
        int    run_at;
    } load_vec_t;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_abort;
    logic        h_in;
    logic        n_in;
    logic        w_in;
    logic        gat_ready;
    logic        gat_layer;
    logic        h_done;
    logic        n_done;
    logic        w_done;
    logic        layer_done;
    logic        busy;
    logic        timeout_err;
    logic [31:0] run_cycles;

    logic                   tready_toggle;
    logic                   tready_fixed;
    logic [7:0]             bram_base;
    logic [FEAT_ADDR_W-1:0] a_q;
    int                     errors;
    int                     checks;
    int                     cyc;
    int                     last_acc;
    int                     ld_count;
    int                     word_cnt;
    logic                   hold_pending;
    logic [7:0]             held_data;
    exp_t                   sb[$];

    gat_layer_sequencer_if #(.DATA_WIDTH(DATA_WIDTH), .FEAT_ADDR_W(FEAT_ADDR_W)) feat_if ();

    gat_layer_sequencer #(
        .NUM_LAYERS (NUM_LAYERS),
        .DATA_WIDTH (DATA_WIDTH),
        .FEAT_DEPTH (FEAT_DEPTH),
        .FEAT_ADDR_W(FEAT_ADDR_W),
        .RD_LAT     (RD_LAT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .cfg_start                 (cfg_start),
        .cfg_abort                 (cfg_abort),
        .h_data_load_done_i        (h_in),
        .h_node_info_load_done_i   (n_in),
        .wgt_load_done_i           (w_in),
        .gat_ready                 (gat_ready),
        .feat                      (feat_if),
        .gat_layer                 (gat_layer),
        .h_data_bram_load_done     (h_done),
        .h_node_info_bram_load_done(n_done),
        .wgt_bram_load_done        (w_done),
        .layer_done                (layer_done),
        .busy                      (busy),
        .timeout_err               (timeout_err),
        .run_cycles                (run_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle BRAM: word k holds bram_base+k+1, upper bits junk the DUT must ignore.
    always @(posedge clk) begin
        a_q                    <= feat_if.feat_bram_addrb;
        feat_if.feat_bram_dout <= {24'hA5A5A5, bram_base + 8'(a_q[4:2]) + 8'd1};
    end

    initial begin
        feat_if.feat_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tready_toggle) feat_if.feat_tready = ~feat_if.feat_tready;
            else feat_if.feat_tready = tready_fixed;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic h, input logic n, input logic w);
        cfg_start = s;
        cfg_abort = a;
        h_in      = h;
        n_in      = n;
        w_in      = w;
        tick();
    endtask

    task automatic pushLayer(input logic [7:0] base);
        exp_t e;
        for (int k = 0; k < FEAT_DEPTH; k++) begin
            e.data = base + 8'(k) + 8'd1;
            e.last = (k == FEAT_DEPTH - 1);
            e.addr = FEAT_ADDR_W'(k * 4);
            sb.push_back(e);
        end
    endtask

    // Stream monitor: scoreboard pop on each handshake, hold stability, layer_done timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold_pending) begin
                checkOutput("hold_tvalid", feat_if.feat_tvalid, 1);
                checkOutput("hold_tdata", feat_if.feat_tdata, held_data);
            end
            hold_pending = feat_if.feat_tvalid && !feat_if.feat_tready && !cfg_abort;
            held_data    = feat_if.feat_tdata;
            if (feat_if.feat_tvalid && feat_if.feat_tready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_word", feat_if.feat_tvalid, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("stream_tdata", feat_if.feat_tdata, e.data);
                    checkOutput("stream_tlast", feat_if.feat_tlast, e.last);
                    checkOutput("stream_addrb", feat_if.feat_bram_addrb, e.addr);
                    word_cnt++;
                end
                if (feat_if.feat_tlast) last_acc = cyc;
            end
            if (layer_done) begin
                checkOutput("layer_done_timing", cyc - last_acc, 1);
                ld_count++;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        load_vec_t vecs[5];
        int        start_cyc;
        int        rise_cyc;
        int        max_off;

        vecs[0] = '{"load_h_w_then_n", 0, 5, 0, 6};
        vecs[1] = '{"load_all_same",   0, 0, 0, 1};
        vecs[2] = '{"load_n_w_h",      3, 1, 2, 4};
        vecs[3] = '{"load_hn_then_w",  2, 2, 6, 7};
        vecs[4] = '{"load_n_then_hw",  4, 0, 4, 5};

        errors        = 0;
        checks        = 0;
        cyc           = 0;
        last_acc      = -10;
        ld_count      = 0;
        word_cnt      = 0;
        hold_pending  = 1'b0;
        held_data     = '0;
        bram_base     = 8'h00;
        tready_toggle = 1'b0;
        tready_fixed  = 1'b0;
        gat_ready     = 1'b0;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        h_in          = 1'b0;
        n_in          = 1'b0;
        w_in          = 1'b0;
        rst_n         = 1'b0;

        repeat (3) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_flags", {h_done, n_done, w_done}, 0);
        checkOutput("rst_tvalid", feat_if.feat_tvalid, 0);
        checkOutput("rst_addrb", feat_if.feat_bram_addrb, 0);
        checkOutput("rst_misc", {gat_layer, layer_done, timeout_err, feat_if.feat_tlast}, 0);
        checkOutput("rst_run_cycles", run_cycles, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] load-flag ordering table");
        foreach (vecs[i]) begin
            max_off = vecs[i].h_off;
            if (vecs[i].n_off > max_off) max_off = vecs[i].n_off;
            if (vecs[i].w_off > max_off) max_off = vecs[i].w_off;
            applyStimulus(1, 0, 0, 0, 0);
            for (int t = 0; t <= max_off + 2; t++) begin
                applyStimulus(0, 0, t == vecs[i].h_off, t == vecs[i].n_off, t == vecs[i].w_off);
                checkOutput({vecs[i].name, "_h"}, h_done, vecs[i].h_off <= t);
                checkOutput({vecs[i].name, "_n"}, n_done, vecs[i].n_off <= t);
                checkOutput({vecs[i].name, "_w"}, w_done, vecs[i].w_off <= t);
                checkOutput({vecs[i].name, "_run_cycles"}, run_cycles,
                            (t + 1 >= vecs[i].run_at) ? 32'(t + 1 - vecs[i].run_at) : 32'd0);
                checkOutput({vecs[i].name, "_busy"}, busy, 1);
                checkOutput({vecs[i].name, "_layer"}, gat_layer, 0);
            end
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput({vecs[i].name, "_abort_flags"}, {h_done, n_done, w_done, busy}, 0);
            checkOutput({vecs[i].name, "_abort_run_cycles"}, run_cycles, 0);
        end

        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("start_with_abort_ignored", busy, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("start_with_abort_still_idle", busy, 0);

        $display("[TB] two-layer run with streaming");
        gat_ready = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("run_busy", busy, 1);
        applyStimulus(0, 0, 1, 1, 1);
        start_cyc = cyc;
        checkOutput("run_flags", {h_done, n_done, w_done}, 3'b111);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("start_in_run_ignored", run_cycles, 2);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stale_ready_ignored", feat_if.feat_tvalid, 0);
        gat_ready = 1'b0;
        repeat (100) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("no_drain_before_rise", feat_if.feat_tvalid, 0);
        bram_base = 8'h00;
        pushLayer(8'h00);
        tready_toggle = 1'b1;
        gat_ready     = 1'b1;
        rise_cyc      = cyc;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run_cycles_at_rise", run_cycles, 32'(rise_cyc - start_cyc + 1));
        checkOutput("run_cycles_ge_100", run_cycles >= 100, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("first_word_not_yet", feat_if.feat_tvalid, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("first_word_valid", feat_if.feat_tvalid, 1);
        checkOutput("first_word_data", feat_if.feat_tdata, 8'h01);
        checkOutput("layer0_flags_held", {h_done, n_done, w_done, gat_layer}, 4'b1110);
        for (int i = 0; i < 200 && ld_count < 1; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("layer0_done", ld_count, 1);
        checkOutput("layer0_words", word_cnt, FEAT_DEPTH);
        checkOutput("layer1_gat_layer", gat_layer, 1);
        checkOutput("layer1_flags_clear", {h_done, n_done, w_done}, 0);
        checkOutput("layer1_busy", busy, 1);

        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("layer1_run_flags", {h_done, n_done, w_done}, 3'b111);
        repeat (4) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("layer1_stale_ready", feat_if.feat_tvalid, 0);
        gat_ready = 1'b0;
        repeat (10) applyStimulus(0, 0, 0, 0, 0);
        bram_base = 8'h10;
        pushLayer(8'h10);
        gat_ready = 1'b1;
        for (int i = 0; i < 200 && ld_count < 2; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("layer1_done", ld_count, 2);
        for (int i = 0; i < 10 && busy; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run_end_busy", busy, 0);
        checkOutput("run_end_words", word_cnt, 2 * FEAT_DEPTH);
        checkOutput("run_end_sb_empty", sb.size(), 0);
        checkOutput("run_end_state", {gat_layer, timeout_err, feat_if.feat_tvalid}, 0);
        checkOutput("run_end_addrb", feat_if.feat_bram_addrb, 0);

        $display("[TB] timeout");
        gat_ready = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1);
        repeat (TIMEOUT_CYC - 1) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timeout_not_yet", timeout_err, 0);
        checkOutput("timeout_run_cycles", run_cycles, TIMEOUT_CYC - 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timeout_set", timeout_err, 1);
        checkOutput("timeout_done_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timeout_idle_busy", busy, 0);
        checkOutput("timeout_no_stream", {feat_if.feat_tvalid, layer_done}, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("timeout_kept_by_abort", timeout_err, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("timeout_cleared_by_start", timeout_err, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("timeout_abort_busy", busy, 0);

        $display("[TB] abort mid-drain");
        tready_toggle = 1'b0;
        tready_fixed  = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1);
        gat_ready = 1'b1;
        for (int i = 0; i < 20 && !feat_if.feat_tvalid; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort_tvalid_seen", feat_if.feat_tvalid, 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("abort_stream", {feat_if.feat_tvalid, feat_if.feat_tlast, feat_if.feat_tdata}, 0);
        checkOutput("abort_addrb", feat_if.feat_bram_addrb, 0);
        checkOutput("abort_flags", {h_done, n_done, w_done, busy, gat_layer, layer_done}, 0);
        checkOutput("abort_run_cycles", run_cycles, 0);

        $display("[TB] reset mid-run");
        gat_ready = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1);
        repeat (5) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pre_reset_run_cycles", run_cycles, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_flags", {h_done, n_done, w_done, busy, gat_layer, timeout_err}, 0);
        checkOutput("async_reset_run_cycles", run_cycles, 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_reset_idle", busy, 0);
        checkOutput("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
